// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_e    : receiver frame FSM states
//   PRESC_MIN/MAX : legal range of the PRESCALE oversampling ratio
//   SAMPLE_OFFSET : the majority-voted bit is ready this many edges after
//                   the mid-bit edge P/2
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PRESC_MIN     = 8;
    localparam int PRESC_MAX     = 32;
    localparam int SAMPLE_OFFSET = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Line synchronizer and 3-sample majority voter for the UART receiver.
// Ports:
//   CLK, RST    : oversampling clock, async active-low reset
//   i_rx_in     : raw serial line (asynchronous to CLK)
//   i_prescale  : latched oversampling ratio P
//   i_edge_cnt  : position inside the current bit, 0..P-1
//   o_rx        : synchronized line value
//   o_bit       : majority of the samples taken at P/2-1, P/2, P/2+1
//   o_bit_vld   : high while i_edge_cnt == P/2+2 (o_bit is final)
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_rx_in,
    input  logic [PRESC_W-1:0] i_prescale,
    input  logic [PRESC_W-1:0] i_edge_cnt,
    output logic               o_rx,
    output logic               o_bit,
    output logic               o_bit_vld
);

    localparam logic [PRESC_W-1:0] C_ONE    = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] C_OFFSET = PRESC_W'(SAMPLE_OFFSET);

    logic               r_sync1;
    logic               r_sync2;
    logic [2:0]         r_samp;
    logic [PRESC_W-1:0] w_half;

    assign w_half = i_prescale >> 1;

    // Synchronizer resets to the idle-high line level so reset release never
    // looks like a start bit.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // In IDLE the edge counter sits at 0, which never matches a sample point
    // for P >= 8, so the samples only move during an active bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samp <= '0;
        end else begin
            if (i_edge_cnt == w_half - C_ONE) r_samp[0] <= r_sync2;
            if (i_edge_cnt == w_half)         r_samp[1] <= r_sync2;
            if (i_edge_cnt == w_half + C_ONE) r_samp[2] <= r_sync2;
        end
    end

    assign o_rx      = r_sync2;
    assign o_bit     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) |
                       (r_samp[1] & r_samp[2]);
    assign o_bit_vld = (i_edge_cnt == w_half + C_OFFSET);

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// Oversampled UART receiver: deframes RX_IN into bytes, checks start, parity
// and stop bits, and reports each frame with exactly one 1-cycle pulse.
// Ports:
//   CLK, RST  : oversampling clock (PRESCALE x baud), async active-low reset
//   RX_IN     : serial line, idle high
//   PRESCALE  : oversampling ratio (even, 8..32), latched at start detect
//   PAR_EN    : parity bit present after data; PAR_TYP 0 = even, 1 = odd
//   P_DATA    : last good byte, held between frames
//   DATA_VLD  : good frame pulse (P_DATA valid)
//   PAR_ERR   : frame dropped on parity mismatch
//   STP_ERR   : frame dropped on stop bit sampled low (wins over parity)
// -----------------------------------------------------------------------------
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VLD,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int                 BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]   C_LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]   C_BIT_ONE  = BIT_W'(1);
    localparam logic [PRESC_W-1:0] C_ONE      = PRESC_W'(1);

    rx_state_e             r_state;
    rx_state_e             w_next_state;
    logic [PRESC_W-1:0]    r_edge_cnt;
    logic [PRESC_W-1:0]    r_presc;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_vld;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic w_rx;
    logic w_bit;
    logic w_bit_vld;
    logic w_bit_end;
    logic w_start_det;

    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .i_rx_in    (RX_IN),
        .i_prescale (r_presc),
        .i_edge_cnt (r_edge_cnt),
        .o_rx       (w_rx),
        .o_bit      (w_bit),
        .o_bit_vld  (w_bit_vld)
    );

    assign w_bit_end   = (r_edge_cnt == r_presc - C_ONE);
    assign w_start_det = (r_state == IDLE) && !w_rx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // NOTE: the default assignment first means every path drives the signal,
    // so no latch is inferred when a state has no transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:   if (!w_rx) w_next_state = START;
            // A start bit that votes high was a glitch: drop it silently.
            START:  if (w_bit_vld && w_bit) w_next_state = IDLE;
                    else if (w_bit_end)     w_next_state = DATA;
            DATA:   if (w_bit_end && r_bit_cnt == C_LAST_BIT)
                        w_next_state = r_par_en ? PARITY : STOP;
            PARITY: if (w_bit_end) w_next_state = STOP;
            // Leave mid-stop-bit so a following start bit is never missed.
            STOP:   if (w_bit_vld) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Frame settings are captured once per frame; later input changes wait.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc   <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_start_det) begin
            r_presc   <= PRESCALE;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (r_state == IDLE || w_next_state == IDLE || w_bit_end)
                r_edge_cnt <= '0;
            else
                r_edge_cnt <= r_edge_cnt + C_ONE;

            if (r_state != DATA)  r_bit_cnt <= '0;
            else if (w_bit_end)   r_bit_cnt <= r_bit_cnt + C_BIT_ONE;
        end
    end

    // NOTE: the shift register is a plain register, not a memory array, so it
    // takes the async reset like every other flop and reset state is fully known.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            if (r_state == DATA && w_bit_vld)
                r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};

            if (w_start_det)
                r_par_bad <= 1'b0;
            else if (r_state == PARITY && w_bit_vld)
                r_par_bad <= ((^r_shift) ^ r_par_typ) != w_bit;
        end
    end

    // Exactly one outcome per frame, decided at the stop-bit vote.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_p_data   <= '0;
            r_data_vld <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else begin
            r_data_vld <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
            if (r_state == STOP && w_bit_vld) begin
                if (!w_bit) begin
                    r_stp_err <= 1'b1;
                end else if (r_par_bad) begin
                    r_par_err <= 1'b1;
                end else begin
                    r_data_vld <= 1'b1;
                    r_p_data   <= r_shift;
                end
            end
        end
    end

    assign P_DATA   = r_p_data;
    assign DATA_VLD = r_data_vld;
    assign PAR_ERR  = r_par_err;
    assign STP_ERR  = r_stp_err;

endmodule
